button_event_queue: RTL and testbench
=====================================

BUTTON_EVENT_QUEUE -- requirements
Module: button_event_queue

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of button inputs, range 1..16.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples needed to accept a level change, minimum 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: event queue entries, power of 2, minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port btn_in, input, N_BTN bits: raw asynchronous button levels, 1 = pressed.
REQ-007 SHALL have port rd_en, input, 1 bit: pop request for the head event.
REQ-008 SHALL have port clr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-009 SHALL have port data_out, output, 32 bits: bit 31 = valid (queue non-empty); bits 3:0 = head event code; all other bits 0.
REQ-010 SHALL have port empty, output, 1 bit: queue holds 0 entries.
REQ-011 SHALL have port full, output, 1 bit: queue holds FIFO_DEPTH entries.
REQ-012 SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: current entry count.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, an event was dropped.
REQ-014 SHALL have port btn_state, output, N_BTN bits: current debounced levels.

Function
REQ-015 SHALL pass each btn_in bit through a 2-flop synchronizer before any other use.
REQ-016 SHALL keep one debounce counter per button; synchronized bit != btn_state bit -> counter increments; equal -> counter clears to 0.
REQ-017 SHALL toggle btn_state bit and clear its counter on the cycle the counter would reach DEBOUNCE_CYCLES, i.e. after DEBOUNCE_CYCLES consecutive differing samples.
REQ-018 SHALL generate a press event only on a debounced 0->1 transition; 1->0 transitions generate no event.
REQ-019 SHALL encode the event for bit i as code N_BTN-1-i; MSB button = code 0 (4-button case: 1000->0, 0100->1, 0010->2, 0001->3).
REQ-020 SHALL, on simultaneous press events in one cycle, enqueue only the lowest code and set overflow; the other events are discarded.
REQ-021 SHALL enqueue an event into the queue tail on the cycle after the btn_state transition; data_out/level reflect it one cycle later.
REQ-022 SHALL present the head entry combinationally from queue registers on data_out; when empty, data_out = 32'h00000000.
REQ-023 SHALL, on rd_en with non-empty queue, remove the head; the next entry or the empty value appears the following cycle.
REQ-024 SHALL ignore rd_en when empty: no pointer change, no flag change.
REQ-025 SHALL, on push while full without pop, drop the new event, leave contents unchanged, set overflow.
REQ-026 SHALL, on push and pop in the same cycle, perform both; level unchanged; no overflow even when full.
REQ-027 SHALL wrap read/write pointers modulo FIFO_DEPTH; level derived from pointer difference with extra wrap bit.
REQ-028 SHALL give overflow set priority over clr_ovf in the same cycle.

Reset
REQ-029 SHALL, on reset assertion, immediately clear synchronizers, counters, btn_state, pointers, overflow; data_out=0, empty=1, full=0, level=0.
REQ-030 SHALL, when reset asserts mid-debounce or with queued events, discard all of them; a button held through reset release is re-debounced from 0 and produces one press event.

Verification (N_BTN=4, DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-031 SHALL test: btn_in=4'b0100 held 10 cycles after reset -> btn_state=0100 after 2+4 cycles; data_out=32'h80000001, level=1; rd_en 1 cycle -> data_out=0, empty=1.
REQ-032 SHALL test: btn_in bit0 toggling every 2 cycles for 20 cycles -> no btn_state change, no event, level=0.
REQ-033 SHALL test: 5 distinct debounced presses, no reads -> full=1, level=4, overflow=1, head=first code; clr_ovf -> overflow=0.
REQ-034 SHALL test: btn_in 0000->1010 in one cycle -> single event code 0 enqueued, overflow=1.
REQ-035 SHALL test: queue full, press completes on the same cycle as rd_en -> level stays 4, overflow stays 0, new code at tail.
REQ-036 SHALL test: reset pulse with level=3 and a debounce in progress -> all outputs at reset values; held button yields exactly one event after release.

Source files
------------

// File: rtl/button_event_queue.sv
// button_event_queue
//   Debounces N_BTN raw button inputs and queues one event per debounced
//   press. Each event is a 4-bit code that identifies the button. The code
//   for input bit i is N_BTN-1-i, so the MSB button gets code 0. The events
//   wait in a small FIFO until software reads them.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   btn_in     raw asynchronous button levels, 1 = pressed
//   rd_en      pop the head event. Ignored while the queue is empty.
//   clr_ovf    clear the sticky overflow flag. A new overflow in the same
//              cycle wins over the clear.
//   data_out   {valid, 27'b0, head code}. All zero when the queue is empty.
//   empty/full queue occupancy flags
//   level      number of entries currently in the queue
//   overflow   sticky flag: at least one event was dropped
//   btn_state  current debounced button levels
//
// Handshake: data_out[31] acts as a valid bit and rd_en acts as a ready bit.
// The head is consumed on a clock edge where both are high. The next entry,
// or the empty value, appears after that edge.
module button_event_queue #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_BTN-1:0]              btn_in,
  input  logic                          rd_en,
  input  logic                          clr_ovf,
  output logic [31:0]                   data_out,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic [N_BTN-1:0]              btn_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] btn_state_q, btn_state_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];

  // Press events detected on a btn_state transition are held for one cycle
  // and then written into the FIFO.
  logic             pend_q, pend_d;
  logic [3:0]       pend_code_q, pend_code_d;
  logic             pend_multi_q, pend_multi_d;

  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       mem_d [FIFO_DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             ovf_q, ovf_d;

  logic [N_BTN-1:0] rise;
  logic [AW:0]      level_w;
  logic             empty_w, full_w, do_pop, do_push, drop;

  // Debounce. A counter runs only while the synchronized input differs from
  // the debounced level. The level toggles on the sample that would bring
  // the counter to DEBOUNCE_CYCLES.
  always_comb begin
    btn_state_d = btn_state_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != btn_state_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          btn_state_d[i] = ~btn_state_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Press detection. When several buttons press in the same cycle, the
  // highest bit index (the lowest code) is kept. The loop runs upward, so
  // the last match is the one that survives.
  always_comb begin
    rise         = btn_state_d & ~btn_state_q;
    pend_d       = |rise;
    pend_code_d  = 4'd0;
    pend_multi_d = ($countones(rise) > 1);
    for (int i = 0; i < N_BTN; i++) begin
      if (rise[i]) pend_code_d = 4'(N_BTN - 1 - i);
    end
  end

  // FIFO. The pointers carry one extra wrap bit, so their difference gives
  // the level directly.
  always_comb begin
    level_w = wptr_q - rptr_q;
    empty_w = (level_w == '0);
    full_w  = (level_w == (AW+1)'(FIFO_DEPTH));
    do_pop  = rd_en & ~empty_w;
    // A pop in the same cycle frees a slot, so a push into a full queue
    // still succeeds.
    do_push = pend_q & (~full_w | do_pop);
    drop    = pend_q & full_w & ~do_pop;

    mem_d = mem_q;
    if (do_push) mem_d[wptr_q[AW-1:0]] = pend_code_q;
    wptr_d = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d = do_pop  ? rptr_q + (AW+1)'(1) : rptr_q;

    if (drop || (pend_q && pend_multi_q)) ovf_d = 1'b1;
    else if (clr_ovf)                     ovf_d = 1'b0;
    else                                  ovf_d = ovf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      btn_state_q  <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
      pend_q       <= 1'b0;
      pend_code_q  <= 4'd0;
      pend_multi_q <= 1'b0;
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= 4'd0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      sync1_q      <= btn_in;
      sync2_q      <= sync1_q;
      btn_state_q  <= btn_state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_code_q  <= pend_code_d;
      pend_multi_q <= pend_multi_d;
      mem_q        <= mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      ovf_q        <= ovf_d;
    end
  end

  assign data_out  = empty_w ? 32'h0 : {1'b1, 27'b0, mem_q[rptr_q[AW-1:0]]};
  assign empty     = empty_w;
  assign full      = full_w;
  assign level     = level_w;
  assign overflow  = ovf_q;
  assign btn_state = btn_state_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Bench for button_event_queue with N_BTN=4, DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
// The driver pushes each expected head word when it issues a press.
// A negedge monitor pops and compares on every accepted read.
// Flag and level checks are made directly with hand-derived constants.
module tb_button_event_queue;

  logic        clk;
  logic        reset;
  logic [3:0]  btn_in;
  logic        rd_en;
  logic        clr_ovf;
  logic [31:0] data_out;
  logic        empty, full, overflow;
  logic [2:0]  level;
  logic [3:0]  btn_state;

  logic [31:0] exp_q[$];
  int          n_cmp;
  int          n_bad;

  button_event_queue #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .rd_en(rd_en),
    .clr_ovf(clr_ovf), .data_out(data_out), .empty(empty), .full(full),
    .level(level), .overflow(overflow), .btn_state(btn_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic press(input logic [3:0] b);
    btn_in = b;
    tick(10);
    btn_in = 4'b0000;
    tick(10);
  endtask

  task automatic pop;
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr;
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
  endtask

  // scoreboard monitor: a read is accepted when rd_en and valid are both high
  always @(negedge clk) begin
    if (!reset && rd_en && data_out[31]) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected: got %h, required no entry", data_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_bad++;
          $display("FAIL pop_head: got %h, required %h", data_out, e);
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; btn_in = 4'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    tick(2);
    check("rst_data", data_out, 32'h0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_level", {29'b0, level}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    reset = 1'b0;
    tick(2);

    // single press of bit 2 -> code 1
    btn_in = 4'b0100;
    tick(5);
    check("t1_state_early", {28'b0, btn_state}, 32'h0);
    tick(1);
    check("t1_state", {28'b0, btn_state}, 32'h4);
    check("t1_level_lat", {29'b0, level}, 32'd0);
    tick(1);
    check("t1_level", {29'b0, level}, 32'd1);
    check("t1_data", data_out, 32'h80000001);
    exp_q.push_back(32'h80000001);
    tick(3);
    pop();
    check("t1_data_after_pop", data_out, 32'h0);
    check("t1_empty", {31'b0, empty}, 32'd1);
    btn_in = 4'b0000;
    tick(10);
    check("t1_release_no_event", {29'b0, level}, 32'd0);
    check("t1_release_state", {28'b0, btn_state}, 32'h0);

    // bouncing input, never stable long enough
    for (int k = 0; k < 10; k++) begin
      btn_in[0] = ~btn_in[0];
      tick(2);
    end
    check("t2_state", {28'b0, btn_state}, 32'h0);
    check("t2_level", {29'b0, level}, 32'd0);
    btn_in = 4'b0000;
    tick(10);

    // five presses with no reads; the fifth is dropped
    press(4'b1000); exp_q.push_back(32'h80000000);
    press(4'b0100); exp_q.push_back(32'h80000001);
    press(4'b0010); exp_q.push_back(32'h80000002);
    press(4'b0001); exp_q.push_back(32'h80000003);
    check("t3_ovf_before", {31'b0, overflow}, 32'd0);
    press(4'b1000);
    check("t3_full", {31'b0, full}, 32'd1);
    check("t3_level", {29'b0, level}, 32'd4);
    check("t3_ovf", {31'b0, overflow}, 32'd1);
    check("t3_head", data_out, 32'h80000000);
    pulse_clr();
    check("t3_ovf_clr", {31'b0, overflow}, 32'd0);

    // full queue: the push lands on the same edge as the pop
    btn_in = 4'b0001;
    tick(6);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    exp_q.push_back(32'h80000003);
    check("t5_level", {29'b0, level}, 32'd4);
    check("t5_ovf", {31'b0, overflow}, 32'd0);
    check("t5_full", {31'b0, full}, 32'd1);
    check("t5_head", data_out, 32'h80000001);
    btn_in = 4'b0000;
    tick(10);
    for (int k = 0; k < 4; k++) pop();
    check("t5_drained", {31'b0, empty}, 32'd1);
    pop();  // read while empty is ignored
    check("t5_empty_pop_level", {29'b0, level}, 32'd0);
    check("t5_empty_pop_ovf", {31'b0, overflow}, 32'd0);

    // simultaneous presses 1010 -> single code 0, overflow set
    btn_in = 4'b1010;
    tick(10);
    check("t4_level", {29'b0, level}, 32'd1);
    check("t4_ovf", {31'b0, overflow}, 32'd1);
    check("t4_data", data_out, 32'h80000000);
    exp_q.push_back(32'h80000000);
    btn_in = 4'b0000;
    tick(10);
    pop();
    check("t4_empty", {31'b0, empty}, 32'd1);
    pulse_clr();

    // reset with three queued events and a debounce in progress
    press(4'b1000);
    press(4'b0100);
    press(4'b0010);
    check("t6_level_pre", {29'b0, level}, 32'd3);
    btn_in = 4'b0001;
    tick(4);
    reset = 1'b1;
    #1;
    check("t6_rst_data", data_out, 32'h0);
    check("t6_rst_empty", {31'b0, empty}, 32'd1);
    check("t6_rst_level", {29'b0, level}, 32'd0);
    check("t6_rst_state", {28'b0, btn_state}, 32'h0);
    check("t6_rst_ovf", {31'b0, overflow}, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(12);
    check("t6_state", {28'b0, btn_state}, 32'h1);
    check("t6_level", {29'b0, level}, 32'd1);
    exp_q.push_back(32'h80000003);
    tick(10);
    check("t6_one_event", {29'b0, level}, 32'd1);
    pop();
    check("t6_empty", {31'b0, empty}, 32'd1);
    btn_in = 4'b0000;
    tick(10);

    check("exp_q_left", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
